// File: rtl/car_motion_controller.sv
`default_nettype none
// ============================================================================
// Module   : car_motion_controller
// Brief    : Moves eight lane cars once per video frame. Odd cars travel right
//            and even cars travel left, each wrapping around the visible line.
//            A player hit freezes all cars for a fixed number of frames, after
//            which every car is put back at its starting x.
// Revision : 1.0 - initial release
// ============================================================================
module car_motion_controller #(
    parameter int H_DISPLAY     = 640,
    parameter int V_DISPLAY     = 480,
    parameter int CAR_SPACING   = 80,
    parameter int FREEZE_FRAMES = 60
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [9:0] h_count,
    input  logic [9:0] v_count,
    input  logic       start,
    input  logic       hit,
    input  logic [1:0] level,
    output logic [9:0] car_x1,
    output logic [9:0] car_x2,
    output logic [9:0] car_x3,
    output logic [9:0] car_x4,
    output logic [9:0] car_x5,
    output logic [9:0] car_x6,
    output logic [9:0] car_x7,
    output logic [9:0] car_x8,
    output logic       frame_tick,
    output logic       running
);

    localparam int          NUM_CARS = 8;
    localparam int          CNT_W    = (FREEZE_FRAMES < 2) ? 1 : $clog2(FREEZE_FRAMES + 1);
    localparam logic [10:0] H_WRAP   = 11'(H_DISPLAY);
    localparam logic [9:0]  V_TICK   = 10'(V_DISPLAY);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FROZEN = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_tick_edge;
    logic [CNT_W-1:0]   r_freeze;
    logic [9:0]         r_pos  [NUM_CARS];
    logic [9:0]         w_next [NUM_CARS];
    logic               w_tick_cond;

    // Starting x of car index i (0-based): evenly spaced across the line.
    function automatic logic [9:0] init_x(input int i);
        return 10'(i * CAR_SPACING);
    endfunction

    assign w_tick_cond = (h_count == 10'd0) && (v_count == V_TICK);

    // Next position of every car, assuming a move happens this cycle.
    always_comb begin
        for (int i = 0; i < NUM_CARS; i++) begin
            logic [10:0] step;
            logic [10:0] x;
            logic [10:0] sum;
            step = 11'((i % 4) + 1) + 11'(level);
            x    = {1'b0, r_pos[i]};
            sum  = 11'd0;
            if ((i % 2) == 0) begin
                // Car numbers 1,3,5,7 move right.
                sum = x + step;
                if (sum >= H_WRAP) begin
                    sum = sum - H_WRAP;
                end
            end else begin
                // Car numbers 2,4,6,8 move left.
                if (x < step) begin
                    sum = x + H_WRAP - step;
                end else begin
                    sum = x - step;
                end
            end
            w_next[i] = sum[9:0];
        end
    end

    // Single-cycle frame pulse on the rising edge of the end-of-frame raster position.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_tick_edge <= 1'b0;
            frame_tick  <= 1'b0;
        end else begin
            r_tick_edge <= w_tick_cond;
            frame_tick  <= w_tick_cond & ~r_tick_edge;
        end
    end

    // Motion state machine: position updates, freeze countdown and running flag.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state  <= IDLE;
            running  <= 1'b0;
            r_freeze <= '0;
            for (int i = 0; i < NUM_CARS; i++) begin
                r_pos[i] <= init_x(i);
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    // A hit wins over a coincident move cycle.
                    if (hit) begin
                        r_state  <= FROZEN;
                        running  <= 1'b0;
                        r_freeze <= CNT_W'(FREEZE_FRAMES);
                    end else if (frame_tick) begin
                        for (int i = 0; i < NUM_CARS; i++) begin
                            r_pos[i] <= w_next[i];
                        end
                    end
                end
                FROZEN: begin
                    if (frame_tick) begin
                        // Counter hitting zero restarts the lanes from scratch.
                        if (r_freeze <= CNT_W'(1)) begin
                            r_freeze <= '0;
                            r_state  <= RUN;
                            running  <= 1'b1;
                            for (int i = 0; i < NUM_CARS; i++) begin
                                r_pos[i] <= init_x(i);
                            end
                        end else begin
                            r_freeze <= r_freeze - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

    assign car_x1 = r_pos[0];
    assign car_x2 = r_pos[1];
    assign car_x3 = r_pos[2];
    assign car_x4 = r_pos[3];
    assign car_x5 = r_pos[4];
    assign car_x6 = r_pos[5];
    assign car_x7 = r_pos[6];
    assign car_x8 = r_pos[7];

endmodule
`default_nettype wire

// File: tb/tb_car_motion_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_car_motion_controller
// Brief    : Directed self-checking bench for car_motion_controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_car_motion_controller;

    logic       CLK;
    logic       RST_N;
    logic [9:0] h_count;
    logic [9:0] v_count;
    logic       start;
    logic       hit;
    logic [1:0] level;
    logic [9:0] car_x1, car_x2, car_x3, car_x4, car_x5, car_x6, car_x7, car_x8;
    logic       frame_tick;
    logic       running;

    int checks   = 0;
    int failures = 0;
    int pulses;

    car_motion_controller #(
        .H_DISPLAY    (640),
        .V_DISPLAY    (480),
        .CAR_SPACING  (80),
        .FREEZE_FRAMES(60)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .h_count   (h_count),
        .v_count   (v_count),
        .start     (start),
        .hit       (hit),
        .level     (level),
        .car_x1    (car_x1),
        .car_x2    (car_x2),
        .car_x3    (car_x3),
        .car_x4    (car_x4),
        .car_x5    (car_x5),
        .car_x6    (car_x6),
        .car_x7    (car_x7),
        .car_x8    (car_x8),
        .frame_tick(frame_tick),
        .running   (running)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // One frame: raise the end-of-frame raster position for one cycle, then
    // wait for the move cycle. Starts and ends on a falling edge.
    task automatic do_tick();
        v_count = 10'd480;
        @(negedge CLK);
        v_count = 10'd0;
        @(negedge CLK);
    endtask

    task automatic do_ticks(input int n);
        for (int k = 0; k < n; k++) do_tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        @(negedge CLK);
    endtask

    task automatic pulse_hit();
        hit = 1'b1;
        @(negedge CLK);
        hit = 1'b0;
        @(negedge CLK);
    endtask

    task automatic apply_reset();
        RST_N = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
    endtask

    initial begin
        RST_N   = 1'b0;
        h_count = 10'd0;
        v_count = 10'd0;
        start   = 1'b0;
        hit     = 1'b0;
        level   = 2'd0;
        #12;
        // Reset state
        check("rst_x1", car_x1, 0);
        check("rst_x2", car_x2, 80);
        check("rst_x8", car_x8, 560);
        check("rst_tick", frame_tick, 0);
        check("rst_running", running, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);

        // Frame pulse: nothing at 479, exactly one pulse for a 5-cycle hold at 480
        v_count = 10'd479;
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            if (frame_tick) pulses++;
        end
        check("no_pulse_479", pulses, 0);
        v_count = 10'd480;
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            if (frame_tick) pulses++;
        end
        check("single_pulse_480", pulses, 1);
        v_count = 10'd0;
        @(negedge CLK);
        check("idle_no_move", car_x1, 0);

        // Hit in IDLE is ignored
        pulse_hit();
        check("idle_hit_ignored", running, 0);

        // Basic motion, level 0
        pulse_start();
        check("start_running", running, 1);
        check("no_move_before_tick", car_x2, 80);
        do_tick();
        check("t1_x1", car_x1, 1);
        check("t1_x2", car_x2, 78);
        check("t1_x3", car_x3, 163);
        check("t1_x4", car_x4, 236);
        check("t1_x8", car_x8, 556);

        // Wrap boundaries
        do_ticks(39);
        check("t40_x2", car_x2, 0);
        do_tick();
        check("t41_x2", car_x2, 638);
        do_ticks(12);
        check("t53_x7", car_x7, 639);
        do_tick();
        check("t54_x7", car_x7, 2);
        check("t54_x1", car_x1, 54);
        check("t54_x5", car_x5, 374);
        check("t54_x6", car_x6, 292);

        // Level 3
        apply_reset();
        level = 2'd3;
        pulse_start();
        do_tick();
        check("lvl3_x1", car_x1, 4);
        check("lvl3_x2", car_x2, 75);
        check("lvl3_x4", car_x4, 233);

        // Hit and freeze
        apply_reset();
        level = 2'd0;
        pulse_start();
        do_ticks(10);
        check("t10_x1", car_x1, 10);
        pulse_hit();
        check("hit_stops", running, 0);
        pulse_start();
        check("frozen_start_ignored", running, 0);
        do_ticks(59);
        check("frz59_x1", car_x1, 10);
        check("frz59_x2", car_x2, 60);
        check("frz59_running", running, 0);
        do_tick();
        check("frz60_x1", car_x1, 0);
        check("frz60_x2", car_x2, 80);
        check("frz60_x8", car_x8, 560);
        check("frz60_running", running, 1);
        do_tick();
        check("resume_x1", car_x1, 1);

        // Hit on the same cycle as the move: no movement, go frozen
        v_count = 10'd480;
        @(negedge CLK);
        v_count = 10'd0;
        hit     = 1'b1;
        @(negedge CLK);
        hit     = 1'b0;
        check("prio_x1", car_x1, 1);
        check("prio_running", running, 0);

        // Asynchronous reset while frozen, between clock edges
        do_ticks(3);
        #2;
        RST_N = 1'b0;
        #1;
        check("async_x1", car_x1, 0);
        check("async_x2", car_x2, 80);
        check("async_x7", car_x7, 480);
        check("async_running", running, 0);
        check("async_tick", frame_tick, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        do_tick();
        check("post_rst_idle_x1", car_x1, 0);
        check("post_rst_running", running, 0);
        pulse_start();
        do_tick();
        check("post_rst_move_x1", car_x1, 1);
        check("post_rst_move_x2", car_x2, 78);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
